exec_stage_mdu: RTL and testbench
=================================

# exec_stage_mdu

Parametrised execute stage with a multi-cycle multiply/divide unit (MDU) and an EX/MEM output register. It sits between the ID/EX latch and the memory stage. It performs single-cycle ALU ops, branch-target generation and destination-register selection. Unsigned multiply/divide runs iteratively into internal HI/LO registers, and the stage back-pressures the decode stage through `in_ready` while the MDU is busy.

## Interface
- `XLEN`, 32: datapath width; also the MDU iteration count.
- `REGW`, 5: register-index width.
- `BR_SHIFT`, 2: left shift applied to `s_extend` before the branch add.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: ID/EX entry present this cycle.
- `in_ready` out 1: stage can accept; equals (state == IDLE).
- `flush` in 1: kill the in-flight entry and abort the MDU.
- `ctlwb_in` in 2, `ctlm_in` in 3: WB/MEM control, passed through.
- `npc`, `rdata1`, `rdata2`, `s_extend` in XLEN: operands.
- `instr_2016`, `instr_1511` in REGW: rt, rd.
- `alu_op` in 2, `funct` in 6, `alusrc` in 1, `regdst` in 1: control.
- `out_valid` out 1: EX/MEM entry valid.
- `ctlwb_out` out 2, `ctlm_out` out 3, `branch_addr_out`, `alu_result_out`, `rdata2_out` out XLEN, `muxout_out` out REGW, `zero_out` out 1: EX/MEM register.

## Operation
- Operand B: `alusrc` ? `s_extend` : `rdata2`. Destination: `regdst` ? rd : rt.
- Branch target: `npc + (s_extend << BR_SHIFT)`, modulo 2^XLEN.
- `alu_op` decode:
  - 00: add.
  - 01: sub.
  - 10: decode `funct`:
    - 100000 add; 100010 sub; 100100 and; 100101 or; 101010 slt (signed).
    - 010000 mfhi; 010010 mflo.
    - 011001 multu; 011011 divu.
    - Any other funct: result 0.
  - 11: or (immediate).
- `zero_out` = (result == 0).
- States:
  - IDLE → MUL on an accepted multu.
  - IDLE → DIV on an accepted divu.
  - MUL/DIV → IDLE after XLEN iterations, or on `flush`.
- MUL: shift-add, one bit per cycle, yields a 2·XLEN product. {HI, LO} = product.
- DIV: restoring, one bit per cycle. LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend. Still takes XLEN cycles.
- HI/LO are written only on the completion edge. An abort leaves them unchanged.
- An accepted mult/div produces no EX/MEM entry: `out_valid` = 0 while busy and on the completion edge.
- `flush` has priority over everything:
  - The next-cycle `out_valid` = 0.
  - An `in_valid` in the same cycle is dropped.
  - A busy MDU returns to IDLE.
- Reset mid-operation: state IDLE, HI = LO = 0, counter 0.

## Timing
- Reset values: `out_valid` 0, all EX/MEM outputs 0, `in_ready` 1, HI = LO = 0.
- Single-cycle op accepted at edge N is visible on the outputs after edge N+1 (1-cycle latency).
- Accept occurs only when `in_valid` && `in_ready` && !`flush`.
- Multu/divu accepted at edge N:
  - `in_ready` is 0 from N+1 through N+XLEN.
  - HI/LO are updated at edge N+XLEN.
  - `in_ready` is 1 after N+XLEN.
  - Total occupancy is XLEN cycles.
- mfhi/mflo accepted in the cycle after completion returns the new HI/LO; there is no hazard window.
- While `in_ready` = 0, input fields are ignored. Upstream holds them.

## Structure
- Package `ex_pkg`: funct code localparams, `alu_sel_t` enum, `mdu_state_t` enum {IDLE, MUL, DIV}.
- Sub-module `ex_mdu`:
  - Holds the iterative mult/div datapath, counter and HI/LO.
  - Interface: `start`, `is_div`, operands, `abort`, `busy`, `hi`, `lo`.
- Top level: ALU, decode, muxes, branch adder and EX/MEM register.

## Test plan
- Reset mid-multu: pulse `rst` low at iteration 10 → `in_ready` = 1, HI = LO = 0, `out_valid` = 0 immediately after reset.
- add, rdata1 = 7, rdata2 = 5 → `alu_result_out` = 12 one cycle later. sub 5−5 → result 0, `zero_out` = 1.
- Branch: `npc` = 0x100, `s_extend` = 0xFFFF_FFFF → `branch_addr_out` = 0xFC.
- multu 0xFFFF_FFFF × 2 → `in_ready` low for 32 cycles. Then mfhi → 1, mflo → 0xFFFF_FFFE.
- divu 100 / 7 → LO = 14, HI = 2. divu 9 / 0 → LO = 0xFFFF_FFFF, HI = 9.
- Flush at divu iteration 5, with HI preloaded to 3 → stage idle next cycle, mfhi returns 3. `flush` with `in_valid` add in the same cycle → `out_valid` = 0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared decode constants and state types for the execute stage and its
// iterative multiply/divide unit.
package ex_pkg;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT,
    ALU_MFHI, ALU_MFLO, ALU_MULTU, ALU_DIVU, ALU_ZERO
  } alu_sel_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV} mdu_state_t;

  function automatic alu_sel_t decode_alu(input logic [1:0] alu_op,
                                          input logic [5:0] funct);
    alu_sel_t sel;
    sel = ALU_ZERO;
    case (alu_op)
      2'b00: sel = ALU_ADD;
      2'b01: sel = ALU_SUB;
      2'b11: sel = ALU_OR;
      default: begin
        case (funct)
          F_ADD:   sel = ALU_ADD;
          F_SUB:   sel = ALU_SUB;
          F_AND:   sel = ALU_AND;
          F_OR:    sel = ALU_OR;
          F_SLT:   sel = ALU_SLT;
          F_MFHI:  sel = ALU_MFHI;
          F_MFLO:  sel = ALU_MFLO;
          F_MULTU: sel = ALU_MULTU;
          F_DIVU:  sel = ALU_DIVU;
          default: sel = ALU_ZERO;
        endcase
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle, with HI/LO result registers written only when an operation completes.
module ex_mdu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            abort,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  mdu_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] work_q, step;
  logic [XLEN-1:0]   opnd_q, hi_q, lo_q;
  logic              done;

  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    sum      = {1'b0, work_q[2*XLEN-1:XLEN]} + {1'b0, (work_q[0] ? opnd_q : '0)};
    mul_next = {sum, work_q[XLEN-1:1]};
    shifted  = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    diff     = shifted - {1'b0, opnd_q};
    div_next = {(diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0]),
                work_q[XLEN-2:0], ~diff[XLEN]};
    step     = (state_q == DIV) ? div_next : mul_next;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = is_div ? DIV : MUL;
          cnt_d   = '0;
        end
      end
      default: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && start) begin
        work_q <= {{XLEN{1'b0}}, (is_div ? op_a : op_b)};
        opnd_q <= is_div ? op_b : op_a;
      end else if (state_q != IDLE && !abort) begin
        work_q <= step;
      end
      if (done) begin
        {hi_q, lo_q} <= step;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/exec_stage_mdu.sv
// Execute stage: ALU, branch adder, destination select and EX/MEM register,
// with back-pressure while the multiply/divide unit is iterating.
module exec_stage_mdu
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REGW     = 5,
  parameter int BR_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [1:0]      ctlwb_in,
  input  logic [2:0]      ctlm_in,
  input  logic [XLEN-1:0] npc,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] s_extend,
  input  logic [REGW-1:0] instr_2016,
  input  logic [REGW-1:0] instr_1511,
  input  logic [1:0]      alu_op,
  input  logic [5:0]      funct,
  input  logic            alusrc,
  input  logic            regdst,
  output logic            out_valid,
  output logic [1:0]      ctlwb_out,
  output logic [2:0]      ctlm_out,
  output logic [XLEN-1:0] branch_addr_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] rdata2_out,
  output logic [REGW-1:0] muxout_out,
  output logic            zero_out
);

  alu_sel_t        sel;
  logic [XLEN-1:0] op_b, result, hi, lo;
  logic            is_mdu, accept, busy;

  logic            out_valid_q;
  logic [1:0]      ctlwb_q;
  logic [2:0]      ctlm_q;
  logic [XLEN-1:0] branch_q, result_q, rdata2_q;
  logic [REGW-1:0] muxout_q;
  logic            zero_q;

  assign sel      = decode_alu(alu_op, funct);
  assign op_b     = alusrc ? s_extend : rdata2;
  assign is_mdu   = (sel == ALU_MULTU) || (sel == ALU_DIVU);
  assign in_ready = !busy;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD:  result = rdata1 + op_b;
      ALU_SUB:  result = rdata1 - op_b;
      ALU_AND:  result = rdata1 & op_b;
      ALU_OR:   result = rdata1 | op_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(rdata1) < $signed(op_b))};
      ALU_MFHI: result = hi;
      ALU_MFLO: result = lo;
      default:  result = '0;
    endcase
  end

  ex_mdu #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_mdu),
    .is_div (sel == ALU_DIVU),
    .op_a   (rdata1),
    .op_b   (rdata2),
    .abort  (flush),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  // Mult/div issue never creates an EX/MEM entry; payload holds when no entry loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      ctlwb_q     <= '0;
      ctlm_q      <= '0;
      branch_q    <= '0;
      result_q    <= '0;
      rdata2_q    <= '0;
      muxout_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= accept && !is_mdu;
      if (accept && !is_mdu) begin
        ctlwb_q  <= ctlwb_in;
        ctlm_q   <= ctlm_in;
        branch_q <= npc + (s_extend << BR_SHIFT);
        result_q <= result;
        rdata2_q <= rdata2;
        muxout_q <= regdst ? instr_1511 : instr_2016;
        zero_q   <= (result == '0);
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign ctlwb_out       = ctlwb_q;
  assign ctlm_out        = ctlm_q;
  assign branch_addr_out = branch_q;
  assign alu_result_out  = result_q;
  assign rdata2_out      = rdata2_q;
  assign muxout_out      = muxout_q;
  assign zero_out        = zero_q;

endmodule

// File: tb/tb_exec_stage_mdu.sv
// Self-checking bench for exec_stage_mdu: directed scenarios plus randomized
// traffic against an arithmetic reference model of the ALU and HI/LO.
module tb_exec_stage_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  ctlwb_in = '0;
  logic [2:0]  ctlm_in = '0;
  logic [31:0] npc = '0, rdata1 = '0, rdata2 = '0, s_extend = '0;
  logic [4:0]  instr_2016 = '0, instr_1511 = '0;
  logic [1:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic        alusrc = 1'b0, regdst = 1'b0;
  logic        in_ready, out_valid, zero_out;
  logic [1:0]  ctlwb_out;
  logic [2:0]  ctlm_out;
  logic [31:0] branch_addr_out, alu_result_out, rdata2_out;
  logic [4:0]  muxout_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  exec_stage_mdu #(.XLEN(32), .REGW(5), .BR_SHIFT(2)) dut (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
    .s_extend(s_extend), .instr_2016(instr_2016), .instr_1511(instr_1511),
    .alu_op(alu_op), .funct(funct), .alusrc(alusrc), .regdst(regdst),
    .out_valid(out_valid), .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out),
    .branch_addr_out(branch_addr_out), .alu_result_out(alu_result_out),
    .rdata2_out(rdata2_out), .muxout_out(muxout_out), .zero_out(zero_out)
  );

  always #5 clk = ~clk;

  // Reference ALU: plain arithmetic from the opcode table.
  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [5:0] fn,
                                               input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return a | b;
      default: begin
        case (fn)
          6'b100000: return a + b;
          6'b100010: return a - b;
          6'b100100: return a & b;
          6'b100101: return a | b;
          6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'b010000: return hi_m;
          6'b010010: return lo_m;
          default:   return 32'd0;
        endcase
      end
    endcase
  endfunction

  task automatic model_mdu(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    if (!is_div) begin
      prod = 64'(a) * 64'(b);
      hi_m = prod[63:32];
      lo_m = prod[31:0];
    end else if (b == 0) begin
      lo_m = 32'hFFFF_FFFF;
      hi_m = a;
    end else begin
      lo_m = a / b;
      hi_m = a % b;
    end
  endtask

  // Presents one entry for a single clock edge; entered and left at a falling edge.
  task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                       input logic src, input logic dst, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [1:0] wb, input logic [2:0] m);
    alu_op = op; funct = fn; rdata1 = a; rdata2 = b; s_extend = imm; npc = pc;
    alusrc = src; regdst = dst; instr_2016 = rt; instr_1511 = rd;
    ctlwb_in = wb; ctlm_in = m; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (!in_ready && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({alu_result_out, branch_addr_out, rdata2_out, muxout_out, zero_out, ctlwb_out, ctlm_out} !== '0)
      begin errors++; $display("[TB] FAIL reset_exmem got=%h/%h/%h exp=0", alu_result_out, branch_addr_out, rdata2_out); end
  endtask

  task automatic test_reset_mid_multu;
    drive(2'b10, 6'b011001, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    drive(2'b10, 6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (alu_result_out !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_hi got=%h exp=0", alu_result_out); end
    drive(2'b10, 6'b010010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (alu_result_out !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_lo got=%h exp=0", alu_result_out); end
  endtask

  task automatic test_add_sub;
    drive(2'b00, 6'd0, 32'd7, 32'd5, 32'd0, 32'd0, 0, 1, 5'd3, 5'd9, 2'b10, 3'b101);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got=%b exp=1", out_valid); end
    checks++; if (alu_result_out !== 32'd12) begin errors++; $display("[TB] FAIL add_result got=%h exp=%h", alu_result_out, 32'd12); end
    checks++; if (muxout_out !== 5'd9) begin errors++; $display("[TB] FAIL add_rd got=%0d exp=9", muxout_out); end
    checks++; if ({ctlwb_out, ctlm_out} !== 5'b10101) begin errors++; $display("[TB] FAIL add_ctl got=%b exp=10101", {ctlwb_out, ctlm_out}); end
    drive(2'b01, 6'd0, 32'd5, 32'd5, 32'd0, 32'd0, 0, 0, 5'd3, 5'd9, 0, 0);
    checks++; if (alu_result_out !== 32'd0) begin errors++; $display("[TB] FAIL sub_result got=%h exp=0", alu_result_out); end
    checks++; if (zero_out !== 1'b1) begin errors++; $display("[TB] FAIL sub_zero got=%b exp=1", zero_out); end
    checks++; if (muxout_out !== 5'd3) begin errors++; $display("[TB] FAIL sub_rt got=%0d exp=3", muxout_out); end
  endtask

  task automatic test_branch;
    drive(2'b00, 6'd0, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h100, 0, 0, 0, 0, 0, 0);
    checks++; if (branch_addr_out !== 32'h0000_00FC) begin errors++; $display("[TB] FAIL branch got=%h exp=000000fc", branch_addr_out); end
  endtask

  task automatic test_multu;
    int cyc;
    drive(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL multu_no_entry got=%b exp=0", out_valid); end
    wait_idle(cyc);
    checks++; if (cyc != 32) begin errors++; $display("[TB] FAIL multu_busy_cycles got=%0d exp=32", cyc); end
    drive(2'b10, 6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (alu_result_out !== 32'd1) begin errors++; $display("[TB] FAIL multu_hi got=%h exp=1", alu_result_out); end
    drive(2'b10, 6'b010010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (alu_result_out !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL multu_lo got=%h exp=fffffffe", alu_result_out); end
  endtask

  task automatic test_divu;
    int cyc;
    logic [31:0] exp_lo [2];
    logic [31:0] exp_hi [2];
    logic [31:0] dvd [2];
    logic [31:0] dvs [2];
    dvd[0] = 32'd100; dvs[0] = 32'd7; exp_lo[0] = 32'd14;         exp_hi[0] = 32'd2;
    dvd[1] = 32'd9;   dvs[1] = 32'd0; exp_lo[1] = 32'hFFFF_FFFF;  exp_hi[1] = 32'd9;
    for (int i = 0; i < 2; i++) begin
      drive(2'b10, 6'b011011, dvd[i], dvs[i], 0, 0, 0, 0, 0, 0, 0, 0);
      wait_idle(cyc);
      checks++; if (cyc != 32) begin errors++; $display("[TB] FAIL divu%0d_busy_cycles got=%0d exp=32", i, cyc); end
      drive(2'b10, 6'b010010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (alu_result_out !== exp_lo[i]) begin errors++; $display("[TB] FAIL divu%0d_lo got=%h exp=%h", i, alu_result_out, exp_lo[i]); end
      drive(2'b10, 6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (alu_result_out !== exp_hi[i]) begin errors++; $display("[TB] FAIL divu%0d_hi got=%h exp=%h", i, alu_result_out, exp_hi[i]); end
    end
    hi_m = 32'd9; lo_m = 32'hFFFF_FFFF;
  endtask

  task automatic test_flush;
    int cyc;
    drive(2'b10, 6'b011011, 32'd3, 32'd5, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_idle(cyc);
    hi_m = 32'd3; lo_m = 32'd0;
    drive(2'b10, 6'b011011, 32'd50, 32'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_idle got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_div_valid got=%b exp=0", out_valid); end
    drive(2'b10, 6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (alu_result_out !== 32'd3) begin errors++; $display("[TB] FAIL flush_hi_kept got=%h exp=3", alu_result_out); end
    flush = 1'b1;
    drive(2'b00, 6'd0, 32'd7, 32'd5, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop_valid got=%b exp=0", out_valid); end
    checks++; if (alu_result_out !== 32'd3) begin errors++; $display("[TB] FAIL flush_drop_hold got=%h exp=3", alu_result_out); end
  endtask

  task automatic test_random;
    logic [5:0]  fns [10];
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b, imm, pc, bsel, exp_r;
    logic        src, dst;
    logic [4:0]  rt, rd;
    logic [1:0]  wb;
    logic [2:0]  m;
    int          cyc;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100; fns[3] = 6'b100101;
    fns[4] = 6'b101010; fns[5] = 6'b010000; fns[6] = 6'b010010; fns[7] = 6'b011001;
    fns[8] = 6'b011011; fns[9] = 6'b000111;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      fn = fns[$urandom_range(0, 9)];
      a = $urandom; b = $urandom; imm = $urandom; pc = $urandom;
      src = 1'($urandom); dst = 1'($urandom);
      rt = 5'($urandom); rd = 5'($urandom); wb = 2'($urandom); m = 3'($urandom);
      if (op == 2'b10 && (fn == 6'b011001 || fn == 6'b011011)) begin
        if (fn == 6'b011011 && $urandom_range(0, 3) == 0) b = 32'd0;
        else if (fn == 6'b011011) b = b >> $urandom_range(0, 31);
        drive(op, fn, a, b, imm, pc, 1'b0, dst, rt, rd, wb, m);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_mdu_valid got=%b exp=0", n, out_valid); end
        wait_idle(cyc);
        checks++; if (cyc != 32) begin errors++; $display("[TB] FAIL rnd%0d_mdu_cycles got=%0d exp=32", n, cyc); end
        model_mdu(fn == 6'b011011, a, b);
      end else begin
        bsel = src ? imm : b;
        exp_r = model_result(op, fn, a, bsel);
        drive(op, fn, a, b, imm, pc, src, dst, rt, rd, wb, m);
        checks++; if (out_valid !== 1'b1 || alu_result_out !== exp_r || zero_out !== (exp_r == 0))
          begin errors++; $display("[TB] FAIL rnd%0d_alu op=%b fn=%b got=%b/%h/%b exp=1/%h/%b", n, op, fn, out_valid, alu_result_out, zero_out, exp_r, exp_r == 0); end
        checks++; if (branch_addr_out !== pc + imm * 4 || rdata2_out !== b || muxout_out !== (dst ? rd : rt) || {ctlwb_out, ctlm_out} !== {wb, m})
          begin errors++; $display("[TB] FAIL rnd%0d_fields got=%h/%h/%0d exp=%h/%h/%0d", n, branch_addr_out, rdata2_out, muxout_out, pc + imm * 4, b, dst ? rd : rt); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset_mid_multu;
    test_add_sub;
    test_branch;
    test_multu;
    test_divu;
    test_flush;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
